uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Bit-level receive controller of the UART RX path. Oversamples the synchronised serial line and recovers each bit by 3-sample majority vote. Frames start/data/parity/stop with an internal edge and bit counter. It drives `sampled_bit` and `par_chk_en` into `parity_check`, takes its `par_err` back, and deserialises the byte to produce `P_DATA`/`data_valid` plus error strobes.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame, LSB first.

Ports:
- `CLK`  in  1  sole clock, oversampling rate = baud × Prescale.
- `RST`  in  1  reset, asynchronous, active-low.
- `RX_IN`  in  1  serial line, already synchronised to `CLK`; idle high.
- `Prescale`  in  6  oversampling ratio. Legal values are 8, 16 and 32; any other value acts as 8.
- `PAR_EN`  in  1  1 = frame carries a parity bit between data and stop.
- `par_err`  in  1  from `parity_check`; sampled at the end of the stop bit.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `par_chk_en`  out  1  1-cycle strobe per data bit and per parity bit; `sampled_bit` is valid while it is high.
- `P_DATA`  out  DATA_W  last accepted byte.
- `data_valid`  out  1  1-cycle strobe when `P_DATA` updates.
- `strt_glitch`  out  1  1-cycle strobe when a false start bit is rejected.
- `stp_err`  out  1  1-cycle strobe when the stop bit samples 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - `edge_cnt` runs 0..P-1 within each bit, where P is the latched Prescale.
  - `bit_cnt` runs 0..DATA_W-1 in DATA.
- IDLE: when `RX_IN`=0, latch Prescale (normalised) and `PAR_EN`. This cycle counts as edge_cnt 0 of the start bit; go to START. Otherwise stay, with counters held at 0.
- Sampling:
  - Take `RX_IN` at edge_cnt P/2-2, P/2-1 and P/2.
  - The majority of the three is registered into `sampled_bit` at edge_cnt P/2+1 and held until the next bit's update.
- START, at edge_cnt P-1:
  - `sampled_bit`=1: pulse `strt_glitch` and return to IDLE.
  - `sampled_bit`=0: go to DATA with bit_cnt=0.
- DATA, at edge_cnt P-1:
  - Pulse `par_chk_en`.
  - Shift `sampled_bit` into the internal shift register, LSB first.
  - Increment bit_cnt.
  - After bit DATA_W-1, go to PARITY if latched PAR_EN, else STOP.
- PARITY, at edge_cnt P-1: pulse `par_chk_en`, then go to STOP. This gives DATA_W+1 strobes per parity frame and DATA_W per non-parity frame.
- STOP, at edge_cnt P-1:
  - `sampled_bit`=0: pulse `stp_err`.
  - Accept the frame when `sampled_bit`=1 and not (latched PAR_EN and `par_err`).
  - On accept: load `P_DATA` from the shift register and pulse `data_valid`.
  - On reject: leave `P_DATA` unchanged.
  - Always return to IDLE.
- Prescale and PAR_EN changes mid-frame are ignored until the next IDLE→START transition.

## Timing
- Reset (RST=0, asynchronous):
  - State IDLE; all counters 0.
  - `sampled_bit`=1, `par_chk_en`=0, `P_DATA`=0, `data_valid`=0, `strt_glitch`=0, `stp_err`=0.
  - Reset mid-frame discards the frame: no strobes, and `P_DATA` is cleared.
- All strobes are registered and high for exactly 1 cycle, in the cycle after edge_cnt P-1 of the relevant bit.
- Latency, counting the first IDLE cycle with `RX_IN`=0 as cycle 0:
  - `data_valid` at cycle 10·P without parity, 11·P with parity (P=8: cycles 80 / 88).
  - `strt_glitch` at cycle P.
- Back-to-back frames: IDLE can detect the next start bit in the same cycle `data_valid` is high. There are zero idle cycles between frames.
- `stp_err` and `data_valid` are mutually exclusive. A stop=1 frame with a parity error produces neither.

## Test plan
- P=8, PAR_EN=0, byte 0xA5 sent (bits 1,0,1,0,0,1,0,1 LSB first) -> 8 `par_chk_en` pulses, `data_valid` at cycle 80, `P_DATA`=0xA5, no error strobes.
- P=16, PAR_EN=1, byte 0x3C, parity bit 0, `par_err`=0 -> 9 `par_chk_en` pulses; the 9th carries `sampled_bit`=0; `data_valid` at cycle 176 with `P_DATA`=0x3C. Repeat with `par_err`=1 -> no `data_valid`, `P_DATA` keeps 0x3C.
- P=8, `RX_IN` low for 2 cycles then high -> `strt_glitch` at cycle 8, state IDLE, no `par_chk_en`.
- P=8, one-cycle inverted pulse on the mid-sample (edge 3) of data bit 2 -> majority holds the correct bit, `P_DATA` correct.
- P=8, byte 0xFF with stop bit 0 -> `stp_err` at cycle 80, no `data_valid`, `P_DATA` unchanged.
- P=32, RST pulsed low during bit 4 -> all outputs at reset values immediately. A following clean frame with 0x5A yields `P_DATA`=0x5A. Two back-to-back frames 0x01, 0x80 -> `data_valid` at cycles 320 and 640.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive bit controller. Frames start/data/parity/stop on an oversampled
// line, votes each bit from three mid-bit samples and deserialises the byte LSB first.
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              par_err,
    output logic              sampled_bit,
    output logic              par_chk_en,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              strt_glitch,
    output logic              stp_err
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]        presc_q, presc_d;
    logic              par_en_q, par_en_d;
    logic [2:0]        samp_q, samp_d;
    logic              sampled_bit_q, sampled_bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              par_chk_en_q, par_chk_en_d;
    logic              data_valid_q, data_valid_d;
    logic              strt_glitch_q, strt_glitch_d;
    logic              stp_err_q, stp_err_d;

    logic [5:0]        halfP;
    logic [5:0]        lastEdge;
    logic              bitEnd;
    logic              lastDataBit;
    logic              majority;

    // Unsupported oversampling ratios fall back to 8.
    function automatic logic [5:0] normPrescale(input logic [5:0] p);
        case (p)
            6'd16:   normPrescale = 6'd16;
            6'd32:   normPrescale = 6'd32;
            default: normPrescale = 6'd8;
        endcase
    endfunction

    assign halfP       = {1'b0, presc_q[5:1]};
    assign lastEdge    = presc_q - 6'd1;
    assign bitEnd      = (state_q != IDLE) && (edge_cnt_q == lastEdge);
    assign lastDataBit = (bit_cnt_q == LAST_BIT);
    assign majority    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d = sampled_bit_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitEnd && lastDataBit) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The IDLE cycle that sees the falling edge is edge 0 of the start bit, so START begins at edge 1.
    always_comb begin
        edge_cnt_d    = edge_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        presc_d       = presc_q;
        par_en_d      = par_en_q;
        samp_d        = samp_q;
        sampled_bit_d = sampled_bit_q;
        shift_d       = shift_q;
        pdata_d       = pdata_q;
        par_chk_en_d  = 1'b0;
        data_valid_d  = 1'b0;
        strt_glitch_d = 1'b0;
        stp_err_d     = 1'b0;

        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            if (!RX_IN) begin
                edge_cnt_d = 6'd1;
                presc_d    = normPrescale(Prescale);
                par_en_d   = PAR_EN;
            end else begin
                edge_cnt_d = 6'd0;
            end
        end else begin
            edge_cnt_d = bitEnd ? 6'd0 : edge_cnt_q + 6'd1;
            if (edge_cnt_q == halfP - 6'd2) begin
                samp_d[0] = RX_IN;
            end
            if (edge_cnt_q == halfP - 6'd1) begin
                samp_d[1] = RX_IN;
            end
            if (edge_cnt_q == halfP) begin
                samp_d[2] = RX_IN;
            end
            if (edge_cnt_q == halfP + 6'd1) begin
                sampled_bit_d = majority;
            end
        end

        if (bitEnd) begin
            case (state_q)
                START: begin
                    bit_cnt_d     = '0;
                    strt_glitch_d = sampled_bit_q;
                end
                DATA: begin
                    par_chk_en_d = 1'b1;
                    shift_d      = {sampled_bit_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d    = lastDataBit ? '0 : bit_cnt_q + BCW'(1);
                end
                PARITY: begin
                    par_chk_en_d = 1'b1;
                end
                STOP: begin
                    stp_err_d = ~sampled_bit_q;
                    if (sampled_bit_q && !(par_en_q && par_err)) begin
                        pdata_d      = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q    <= 6'd0;
            bit_cnt_q     <= '0;
            presc_q       <= 6'd8;
            par_en_q      <= 1'b0;
            samp_q        <= 3'b111;
            sampled_bit_q <= 1'b1;
            shift_q       <= '0;
            pdata_q       <= '0;
            par_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            presc_q       <= presc_d;
            par_en_q      <= par_en_d;
            samp_q        <= samp_d;
            sampled_bit_q <= sampled_bit_d;
            shift_q       <= shift_d;
            pdata_q       <= pdata_d;
            par_chk_en_q  <= par_chk_en_d;
            data_valid_q  <= data_valid_d;
            strt_glitch_q <= strt_glitch_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign par_chk_en  = par_chk_en_q;
    assign P_DATA      = pdata_q;
    assign data_valid  = data_valid_q;
    assign strt_glitch = strt_glitch_q;
    assign stp_err     = stp_err_q;

endmodule
